// File: rtl/axi_drop_packet_multi.sv
// AXI-Stream packet FIFO that drops a packet on error or on oversize.
// Each packet is staged in a circular RAM. It becomes readable only after its
// tlast is accepted without error. A packet with an error, or one longer than
// the buffer, is rewound away. Both kinds of drop are counted in saturating
// counters.
module axi_drop_packet_multi #(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 6,
  parameter int ERR_ANY_BEAT = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  input  logic             i_tlast,
  input  logic             i_terror,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  output logic             o_tlast,
  input  logic             o_tready,
  output logic [CNT_W-1:0] drop_err_cnt,
  output logic [CNT_W-1:0] drop_oversize_cnt
);
  localparam int DEPTH = 2**SIZE;
  localparam logic [SIZE:0]    PTR_ONE = {{SIZE{1'b0}}, 1'b1};
  localparam logic [SIZE:0]    DEPTH_W = {1'b1, {SIZE{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [0:0] ST_ACCEPT  = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [WIDTH:0]   ram [DEPTH];
  logic [SIZE:0]    wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  // Reader sees the commit pointer one cycle late, so that commit and read of
  // the same packet never land on the same edge.
  logic [SIZE:0]    commit_vis_q;
  logic [0:0]       state_q, state_d;
  logic             bad_q, bad_d, en_q;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             o_last_q, o_last_d, o_vld_q, o_vld_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, ovs_cnt_q, ovs_cnt_d;

  logic [SIZE:0]  wr_inc, unc_len;
  logic           full, in_fire, wr_en, rd_load;
  logic [WIDTH:0] ram_rd;

  assign wr_inc   = wr_ptr_q + PTR_ONE;
  assign unc_len  = wr_inc - commit_ptr_q;
  assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_W;
  assign i_tready = en_q & ~clear & ((state_q == ST_DISCARD) | ~full);
  assign in_fire  = i_tvalid & i_tready;
  assign wr_en    = in_fire & (state_q == ST_ACCEPT);
  assign ram_rd   = ram[rd_ptr_q[SIZE-1:0]];
  assign rd_load  = (commit_vis_q != rd_ptr_q) & (~o_vld_q | o_tready);

  assign o_tvalid          = o_vld_q & ~clear;
  assign o_tdata           = clear ? '0 : o_data_q;
  assign o_tlast           = o_last_q & ~clear;
  assign drop_err_cnt      = clear ? '0 : err_cnt_q;
  assign drop_oversize_cnt = clear ? '0 : ovs_cnt_q;

  // Write side: accept or discard packets, commit, rewind and count drops.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    state_d      = state_q;
    bad_d        = bad_q;
    err_cnt_d    = err_cnt_q;
    ovs_cnt_d    = ovs_cnt_q;
    if (in_fire) begin
      if (state_q == ST_ACCEPT) begin
        wr_ptr_d = wr_inc;
        if (i_tlast) begin
          if (i_terror | ((ERR_ANY_BEAT != 0) & bad_q)) begin
            wr_ptr_d  = commit_ptr_q;
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_ONE;
          end else begin
            commit_ptr_d = wr_inc;
          end
          bad_d = 1'b0;
        end else if (unc_len == DEPTH_W) begin
          // The buffer is full of this one packet and tlast is still to come,
          // so the packet can never fit.
          wr_ptr_d  = commit_ptr_q;
          state_d   = ST_DISCARD;
          bad_d     = 1'b0;
          ovs_cnt_d = (ovs_cnt_q == '1) ? ovs_cnt_q : ovs_cnt_q + CNT_ONE;
        end else if (ERR_ANY_BEAT != 0) begin
          bad_d = bad_q | i_terror;
        end
      end else if (i_tlast) begin
        state_d = ST_ACCEPT;
        bad_d   = 1'b0;
      end
    end
  end

  // Read side: a single output register, refilled whenever it empties or is taken.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    o_data_d = o_data_q;
    o_last_d = o_last_q;
    o_vld_d  = o_vld_q & ~o_tready;
    if (rd_load) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      o_data_d = ram_rd[WIDTH-1:0];
      o_last_d = ram_rd[WIDTH];
      o_vld_d  = 1'b1;
    end
  end

  // Packet RAM: holds {tlast, tdata}, with no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr_q[SIZE-1:0]] <= {i_tlast, i_tdata};
  end

  // State registers: asynchronous reset, synchronous flush on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0; commit_ptr_q <= '0; rd_ptr_q <= '0; commit_vis_q <= '0;
      state_q <= ST_ACCEPT; bad_q <= 1'b0; en_q <= 1'b0;
      o_data_q <= '0; o_last_q <= 1'b0; o_vld_q <= 1'b0;
      err_cnt_q <= '0; ovs_cnt_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0; commit_ptr_q <= '0; rd_ptr_q <= '0; commit_vis_q <= '0;
      state_q <= ST_ACCEPT; bad_q <= 1'b0; en_q <= 1'b0;
      o_data_q <= '0; o_last_q <= 1'b0; o_vld_q <= 1'b0;
      err_cnt_q <= '0; ovs_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d; commit_ptr_q <= commit_ptr_d; rd_ptr_q <= rd_ptr_d;
      commit_vis_q <= commit_ptr_q;
      state_q <= state_d; bad_q <= bad_d; en_q <= 1'b1;
      o_data_q <= o_data_d; o_last_q <= o_last_d; o_vld_q <= o_vld_d;
      err_cnt_q <= err_cnt_d; ovs_cnt_q <= ovs_cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_drop_packet_multi.sv
// Bench for axi_drop_packet_multi. It uses two instances:
//   dut0: WIDTH=64 SIZE=6 ERR_ANY_BEAT=0 CNT_W=16 (directed tests)
//   dut1: WIDTH=64 SIZE=5 ERR_ANY_BEAT=1 CNT_W=4  (error mode 1 and random traffic)
// A packet-level model sits in the checker. Each complete input packet is
// kept when it fits and is clean. Otherwise it is counted as a drop.
module tb_axi_drop_packet_multi;
  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic        rst_n, clear;
  logic [1:0]  iv, il, ie, ordy, rmode;
  logic [63:0] id [2];
  logic        irdy0, irdy1, ov0, ov1, ol0, ol1;
  logic [63:0] od0, od1;
  logic [15:0] ec0, oc0;
  logic [3:0]  ec1, oc1;
  logic [1:0]  irdy, ov;
  assign irdy = {irdy1, irdy0};
  assign ov   = {ov1, ov0};

  axi_drop_packet_multi #(.WIDTH(64), .SIZE(6), .ERR_ANY_BEAT(0), .CNT_W(16)) dut0 (
    .clk(gclk), .reset_n(rst_n), .clear(clear),
    .i_tdata(id[0]), .i_tvalid(iv[0]), .i_tlast(il[0]), .i_terror(ie[0]), .i_tready(irdy0),
    .o_tdata(od0), .o_tvalid(ov0), .o_tlast(ol0), .o_tready(ordy[0]),
    .drop_err_cnt(ec0), .drop_oversize_cnt(oc0));

  axi_drop_packet_multi #(.WIDTH(64), .SIZE(5), .ERR_ANY_BEAT(1), .CNT_W(4)) dut1 (
    .clk(gclk), .reset_n(rst_n), .clear(clear),
    .i_tdata(id[1]), .i_tvalid(iv[1]), .i_tlast(il[1]), .i_terror(ie[1]), .i_tready(irdy1),
    .o_tdata(od1), .o_tvalid(ov1), .o_tlast(ol1), .o_tready(ordy[1]),
    .drop_err_cnt(ec1), .drop_oversize_cnt(oc1));

  int n_pass = 0, n_tot = 0, cyc = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int smin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- packet-level reference model ----------------
  logic [64:0] exp_buf [2][65536];
  logic [64:0] cur_buf [2][128];
  int          head [2], tail [2], cur_len [2], m_err [2], m_ovs [2], pop_cnt [2];
  int          first_pop [2], last_pop [2];
  bit          cur_err [2];
  logic [64:0] last_word [2];

  task automatic model_beat(input int d, input logic [64:0] w, input bit err);
    int depth, sat;
    bit bad;
    depth = (d == 0) ? 64 : 32;
    sat   = (d == 0) ? 65535 : 15;
    if (cur_len[d] < 128) cur_buf[d][cur_len[d]] = w;
    cur_len[d]++;
    cur_err[d] = cur_err[d] | err;
    if (w[64]) begin
      bad = (d == 0) ? err : cur_err[d];
      if (cur_len[d] > depth) m_ovs[d] = smin(m_ovs[d] + 1, sat);
      else if (bad)           m_err[d] = smin(m_err[d] + 1, sat);
      else for (int i = 0; i < cur_len[d]; i++) begin
        exp_buf[d][tail[d]] = cur_buf[d][i];
        tail[d]++;
      end
      cur_len[d] = 0;
      cur_err[d] = 1'b0;
    end
  endtask

  // Compare process: checks every cycle, away from the active edge.
  logic [63:0] c_dat;
  logic        c_v, c_l, c_r;
  logic [15:0] c_e, c_o;
  always @(negedge gclk) begin
    for (int d = 0; d < 2; d++) begin
      c_dat = d ? od1 : od0;
      c_v   = d ? ov1 : ov0;
      c_l   = d ? ol1 : ol0;
      c_r   = d ? irdy1 : irdy0;
      c_e   = d ? {12'b0, ec1} : ec0;
      c_o   = d ? {12'b0, oc1} : oc0;
      if (!rst_n || clear) begin
        cur_len[d] = 0; cur_err[d] = 1'b0; head[d] = tail[d]; m_err[d] = 0; m_ovs[d] = 0;
        chk(!c_v && !c_r && !c_l && c_dat == 0 && c_e == 0 && c_o == 0, "reset_vals",
            {30'b0, c_r, c_v, c_e, c_o}, 64'd0);
      end else begin
        if (c_v) begin
          if (head[d] == tail[d]) chk(1'b0, "spurious_out", c_dat, 64'd0);
          else begin
            chk({c_l, c_dat} == exp_buf[d][head[d]], d ? "out_word1" : "out_word0",
                {c_l, c_dat[62:0]}, {exp_buf[d][head[d]][64], exp_buf[d][head[d]][62:0]});
            if (ordy[d]) begin
              last_word[d] = exp_buf[d][head[d]];
              head[d]++; pop_cnt[d]++;
              if (first_pop[d] < 0) first_pop[d] = cyc;
              last_pop[d] = cyc;
            end
          end
        end
        if (cur_len[d] == 0) begin
          chk(c_e == m_err[d][15:0], "err_cnt", c_e, m_err[d]);
          chk(c_o == m_ovs[d][15:0], "ovs_cnt", c_o, m_ovs[d]);
        end
        if (iv[d] && c_r) model_beat(d, {il[d], id[d]}, ie[d]);
      end
    end
    cyc++;
  end

  // Random output back-pressure, used when rmode is set for that instance.
  int stall [2];
  initial begin
    stall[0] = 0; stall[1] = 0;
    forever begin
      @(posedge gclk); #1;
      for (int d = 0; d < 2; d++) if (rmode[d]) begin
        if (stall[d] > 0) stall[d]--;
        else if ($urandom_range(0, 31) == 0) stall[d] = $urandom_range(1, 16);
        ordy[d] = (stall[d] == 0);
      end
    end
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
  task automatic beat(input int d, input logic [63:0] data, input bit last, input bit err, output int waits);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    iv[d] = 1'b1; id[d] = data; il[d] = last; ie[d] = err;
    while (!acc && n < 3000) begin
      @(negedge gclk); acc = irdy[d];
      @(posedge gclk); #1;
      if (!acc) n++;
    end
    iv[d] = 1'b0; il[d] = 1'b0; ie[d] = 1'b0;
    if (!acc) chk(1'b0, "beat_timeout", n, 0);
    waits = n;
  endtask

  task automatic send(input int d, input int len, input int base, input int err_idx, output int waits);
    int w;
    waits = 0;
    for (int i = 0; i < len; i++) begin
      beat(d, 64'(base + i), i == len - 1, i == err_idx, w);
      waits += w;
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while ((head[d] != tail[d] || ov[d]) && n < 20000) begin
      @(posedge gclk); #1; n++;
    end
    chk(n < 20000, "drain_timeout", n, 20000);
  endtask

  task automatic do_clear();
    clear = 1'b1; @(posedge gclk); #1;
    clear = 1'b0; @(posedge gclk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_tot + 1);
    $fatal(1, "watchdog");
  end

  int w, p, ogen, egen, len;
  bit anyerr, e;
  initial begin
    rst_n = 1'b0; clear = 1'b0; iv = '0; il = '0; ie = '0; ordy = '0; rmode = '0;
    id[0] = '0; id[1] = '0;
    for (int d = 0; d < 2; d++) begin
      head[d] = 0; tail[d] = 0; cur_len[d] = 0; m_err[d] = 0; m_ovs[d] = 0; cur_err[d] = 1'b0;
      pop_cnt[d] = 0; first_pop[d] = -1; last_pop[d] = -1; last_word[d] = '0;
    end
    repeat (3) @(posedge gclk);
    #1 rst_n = 1'b1;
    @(negedge gclk); chk(irdy == 2'b00, "rdy_before_edge", irdy, 0);
    @(posedge gclk); #1;
    @(negedge gclk); chk(irdy == 2'b11, "rdy_after_edge", irdy, 3);
    @(posedge gclk); #1;

    // Reset mid-packet: the unterminated beats must never appear.
    ordy[0] = 1'b1;
    for (int i = 0; i < 10; i++) beat(0, 64'(500 + i), 1'b0, 1'b0, w);
    rst_n = 1'b0; repeat (2) @(posedge gclk); #1;
    rst_n = 1'b1; @(posedge gclk); #1;
    p = pop_cnt[0];
    send(0, 4, 100, -1, w);
    wait_drain(0);
    chk(pop_cnt[0] - p == 4, "rst_pkt_words", pop_cnt[0] - p, 4);
    chk(last_word[0] == {1'b1, 64'd103}, "rst_pkt_last", last_word[0][63:0], 103);

    // Fill: one 64-word packet into an un-drained buffer, then check the latency.
    ordy[0] = 1'b0;
    p = pop_cnt[0];
    send(0, 64, 0, -1, w);
    chk(w == 0, "fill_no_stall", w, 0);
    @(negedge gclk);
    chk(irdy0 == 1'b0, "fill_full_rdy", irdy0, 0);
    chk(ov0 == 1'b0, "lat_edge1", ov0, 0);
    @(posedge gclk); #1; @(negedge gclk);
    chk(ov0 == 1'b0, "lat_edge1b", ov0, 0);
    @(posedge gclk); #1; @(negedge gclk);
    chk(ov0 == 1'b1, "lat_edge2", ov0, 1);
    @(posedge gclk); #1;
    ordy[0] = 1'b1;
    wait_drain(0);
    chk(pop_cnt[0] - p == 64, "fill_words", pop_cnt[0] - p, 64);
    chk(last_word[0] == {1'b1, 64'd63}, "fill_last", last_word[0][63:0], 63);

    // Error drop: terror on beat 3 of the middle packet, in both error modes.
    do_clear();
    for (int d = 0; d < 2; d++) begin
      ordy[d] = 1'b1;
      p = pop_cnt[d];
      for (int k = 0; k < 3; k++) send(d, 16, k * 16, (k == 1) ? 2 : -1, w);
      wait_drain(d);
      @(negedge gclk);
      chk(pop_cnt[d] - p == (d ? 32 : 48), "errtest_words", pop_cnt[d] - p, d ? 32 : 48);
      chk((d ? {12'b0, ec1} : ec0) == (d ? 16'd1 : 16'd0), "errtest_cnt", d ? {12'b0, ec1} : ec0, d);
      chk(m_err[d] == d, "errtest_model", m_err[d], d);
      @(posedge gclk); #1;
    end

    // Oversize: a 70-word packet is dropped and a 5-word packet passes.
    do_clear();
    p = pop_cnt[0];
    send(0, 70, 1000, -1, w);
    chk(w == 0, "ovs_no_stall", w, 0);
    send(0, 5, 2000, -1, w);
    wait_drain(0);
    @(negedge gclk);
    chk(oc0 == 16'd1, "ovs_cnt_lit", oc0, 1);
    chk(pop_cnt[0] - p == 5, "ovs_words", pop_cnt[0] - p, 5);
    chk(last_word[0] == {1'b1, 64'd2004}, "ovs_last", last_word[0][63:0], 2004);
    @(posedge gclk); #1;

    // Back-to-back packets must sustain one word per cycle.
    do_clear();
    p = pop_cnt[0]; first_pop[0] = -1;
    ogen = 0;
    for (int k = 0; k < 10; k++) begin
      send(0, 32, k * 32, -1, w);
      ogen += w;
    end
    chk(ogen == 0, "b2b_no_stall", ogen, 0);
    wait_drain(0);
    chk(pop_cnt[0] - p == 320, "b2b_words", pop_cnt[0] - p, 320);
    chk(last_pop[0] - first_pop[0] == 319, "b2b_rate", last_pop[0] - first_pop[0], 319);
    chk(last_word[0] == {1'b1, 64'd319}, "b2b_last", last_word[0][63:0], 319);

    // Random traffic into the small buffer, with error mode 1 and 4-bit counters.
    do_clear();
    rmode[1] = 1'b1;
    ogen = 0; egen = 0;
    for (int k = 0; k < 2000; k++) begin
      len = $urandom_range(1, 40);
      anyerr = 1'b0;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 31) == 0) begin
          repeat ($urandom_range(1, 16)) @(posedge gclk);
          #1;
        end
        e = ($urandom_range(0, 7) == 0);
        anyerr |= e;
        beat(1, {$urandom, $urandom}, i == len - 1, e, w);
      end
      if (len > 32) ogen++;
      else if (anyerr) egen++;
    end
    wait_drain(1);
    @(negedge gclk);
    chk(oc1 == 4'(smin(ogen, 15)), "rnd_ovs_total", oc1, smin(ogen, 15));
    chk(ec1 == 4'(smin(egen, 15)), "rnd_err_total", ec1, smin(egen, 15));
    chk(m_ovs[1] == smin(ogen, 15), "rnd_model_ovs", m_ovs[1], smin(ogen, 15));
    chk(head[1] == tail[1], "rnd_all_out", head[1], tail[1]);
    @(posedge gclk); #1;
    rmode[1] = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
